// File: rtl/dnn_result_argmax.sv
// Argmax output stage: captures all class scores on start, scans one class per cycle,
// and reports the winner, its score, the runner-up margin and a low-confidence flag.
module dnn_result_argmax #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned N_CLASSES   = 10,
  parameter int unsigned IDX_WIDTH   = $clog2(N_CLASSES),
  parameter int unsigned CONF_THRESH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              start,
  input  logic [N_CLASSES*DATA_WIDTH-1:0]   scores,
  output logic                              busy,
  output logic                              done,
  output logic                              result_valid,
  output logic [IDX_WIDTH-1:0]              best_idx,
  output logic signed [DATA_WIDTH-1:0]      best_score,
  output logic [DATA_WIDTH:0]               margin,
  output logic                              low_conf,
  input  logic [IDX_WIDTH-1:0]              rd_idx,
  output logic signed [DATA_WIDTH-1:0]      rd_data
);

  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FIN
  } state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   score_buf_q [N_CLASSES];
  logic signed [DATA_WIDTH-1:0]   score_buf_d [N_CLASSES];
  logic [IDX_WIDTH-1:0]           cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   best_q, best_d;
  logic signed [DATA_WIDTH-1:0]   second_q, second_d;
  logic [IDX_WIDTH-1:0]           bidx_q, bidx_d;

  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           valid_q, valid_d;
  logic [IDX_WIDTH-1:0]           best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0]   best_score_q, best_score_d;
  logic [DATA_WIDTH:0]            margin_q, margin_d;
  logic                           low_conf_q, low_conf_d;
  logic signed [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic signed [DATA_WIDTH-1:0]   cur;
  logic [DATA_WIDTH:0]            margin_calc;

  // Sign-extended difference; best never falls below second, so the result is non-negative.
  assign margin_calc = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
  assign cur         = score_buf_q[cnt_q];

  always_comb begin
    state_d      = state_q;
    score_buf_d  = score_buf_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    second_d     = second_q;
    bidx_d       = bidx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    margin_d     = margin_q;
    low_conf_d   = low_conf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < N_CLASSES; k++) begin
            score_buf_d[k] = scores[k*DATA_WIDTH +: DATA_WIDTH];
          end
          cnt_d    = '0;
          best_d   = MIN_SCORE;
          second_d = MIN_SCORE;
          bidx_d   = '0;
          busy_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compares keep the lowest index on ties and push the tied value into second.
        if (cur > best_q) begin
          second_d = best_q;
          best_d   = cur;
          bidx_d   = cnt_q;
        end else if (cur > second_q) begin
          second_d = cur;
        end
        if (cnt_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + IDX_WIDTH'(1);
        end
      end
      S_FIN: begin
        best_idx_d   = bidx_q;
        best_score_d = best_q;
        margin_d     = margin_calc;
        low_conf_d   = (32'(margin_calc) < CONF_THRESH);
        done_d       = 1'b1;
        valid_d      = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear drops results and any scan in flight but keeps the captured buffer.
    if (clear) begin
      state_d      = S_IDLE;
      score_buf_d  = score_buf_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      valid_d      = 1'b0;
      best_idx_d   = '0;
      best_score_d = '0;
      margin_d     = '0;
      low_conf_d   = 1'b0;
    end
  end

  // Registered readout; out-of-range indices fall back to class 0.
  always_comb begin
    rd_data_d = score_buf_q[0];
    if (32'(rd_idx) < N_CLASSES) begin
      rd_data_d = score_buf_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      for (int unsigned k = 0; k < N_CLASSES; k++) begin
        score_buf_q[k] <= '0;
      end
      cnt_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      bidx_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      margin_q     <= '0;
      low_conf_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      score_buf_q  <= score_buf_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      second_q     <= second_d;
      bidx_q       <= bidx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      margin_q     <= margin_d;
      low_conf_q   <= low_conf_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign best_idx     = best_idx_q;
  assign best_score   = best_score_q;
  assign margin       = margin_q;
  assign low_conf     = low_conf_q;
  assign rd_data      = rd_data_q;

endmodule
